// File: rtl/bcd_updown_scan_counter.sv
//------------------------------------------------------------------------------
// bcd_updown_scan_counter
// Multi-digit BCD up/down counter with preload, wrap/saturate limits and a
// time-multiplexed, active-low seven-segment scanner with leading-zero blanking.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_updown_scan_counter #(
    parameter int DIGITS   = 8,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 100000,
    parameter int SAT      = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  go,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  limit,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(DIGITS - 1);

    // Registered state and next-state values
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic                  limit_q, limit_d;
    logic [SW-1:0]         scnt_q, scnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;

    // Combinational helpers
    logic [4*DIGITS-1:0]   inc_v, dec_v, load_clean;
    logic                  carry, borrow, at_max, at_min, strobe;
    logic [3:0]            dig;
    logic [DIGITS-1:0]     blank;
    logic                  hi_zero;
    logic [3:0]            sel_dig;
    logic                  sel_blank;

    // Active-low {dp,g,f,e,d,c,b,a} pattern for one BCD digit; dp kept off
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    // Ripple decimal increment/decrement; a carry/borrow surviving all digits marks the limit
    always_comb begin
        inc_v      = count_q;
        dec_v      = count_q;
        load_clean = load_val;
        carry      = 1'b1;
        borrow     = 1'b1;
        dig        = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    inc_v[4*i +: 4] = 4'd0;
                end else begin
                    inc_v[4*i +: 4] = dig + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (dig == 4'd0) begin
                    dec_v[4*i +: 4] = 4'd9;
                end else begin
                    dec_v[4*i +: 4] = dig - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > 4'd9) begin
                load_clean[4*i +: 4] = 4'd0;
            end
        end
        at_max = carry;
        at_min = borrow;
    end

    // Tick divider, preload and step selection; load discards any coincident step
    always_comb begin
        tcnt_d  = tcnt_q;
        count_d = count_q;
        limit_d = 1'b0;
        strobe  = go && (tcnt_q == TICK_LAST);
        if (load) begin
            tcnt_d  = '0;
            count_d = load_clean;
        end else begin
            if (go) begin
                tcnt_d = strobe ? '0 : tcnt_q + TW'(1);
            end
            if (strobe) begin
                if (up) begin
                    limit_d = at_max;
                    count_d = (at_max && (SAT != 0)) ? count_q : inc_v;
                end else begin
                    limit_d = at_min;
                    count_d = (at_min && (SAT != 0)) ? count_q : dec_v;
                end
            end
        end
    end

    // Digit scanner, blanking mask and the segment/anode values for the current digit
    always_comb begin
        scnt_d = scnt_q + SW'(1);
        idx_d  = idx_q;
        if (scnt_q == SCAN_LAST) begin
            scnt_d = '0;
            idx_d  = (idx_q == DIGIT_LAST) ? '0 : idx_q + IW'(1);
        end

        // A digit is blanked when it and every digit above it are zero
        hi_zero = 1'b1;
        blank   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero  = hi_zero & (count_q[4*i +: 4] == 4'd0);
            blank[i] = (BLANK_LZ != 0) && (i != 0) && hi_zero;
        end

        sel_dig   = 4'd0;
        sel_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                sel_dig   = count_q[4*i +: 4];
                sel_blank = blank[i];
            end
        end
        seg_d = sel_blank ? 8'hFF : seg_decode(sel_dig);
        an_d  = ~(DIGITS'(1) << idx_q);
    end

    // State registers with asynchronous active-low clear to a blank display
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt_q  <= '0;
            count_q <= '0;
            limit_q <= 1'b0;
            scnt_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 8'hFF;
            an_q    <= '1;
        end else begin
            tcnt_q  <= tcnt_d;
            count_q <= count_d;
            limit_q <= limit_d;
            scnt_q  <= scnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign count = count_q;
    assign limit = limit_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_updown_scan_counter.sv
//------------------------------------------------------------------------------
// tb_bcd_updown_scan_counter
// Directed bench for the BCD scan counter: wrap, saturate, blanking-off and
// single-digit variants share one stimulus stream.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_updown_scan_counter;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        go = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;

    logic [15:0] count_m, count_s, count_n;
    logic        limit_m, limit_s, limit_n, limit_1;
    logic [7:0]  seg_m, seg_s, seg_n, seg_1;
    logic [3:0]  an_m, an_s, an_n;
    logic [3:0]  count_1;
    logic        an_1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bcd_updown_scan_counter #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .SAT(0), .BLANK_LZ(1)) u_main (
        .clk(clk), .rstn(rstn), .go(go), .up(up), .load(load), .load_val(load_val),
        .count(count_m), .limit(limit_m), .seg(seg_m), .an(an_m));

    bcd_updown_scan_counter #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .SAT(1), .BLANK_LZ(1)) u_sat (
        .clk(clk), .rstn(rstn), .go(go), .up(up), .load(load), .load_val(load_val),
        .count(count_s), .limit(limit_s), .seg(seg_s), .an(an_s));

    bcd_updown_scan_counter #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .SAT(0), .BLANK_LZ(0)) u_nb (
        .clk(clk), .rstn(rstn), .go(go), .up(up), .load(load), .load_val(load_val),
        .count(count_n), .limit(limit_n), .seg(seg_n), .an(an_n));

    bcd_updown_scan_counter #(.DIGITS(1), .TICK_DIV(4), .SCAN_DIV(2), .SAT(0), .BLANK_LZ(1)) u_one (
        .clk(clk), .rstn(rstn), .go(go), .up(up), .load(load), .load_val(load_val[3:0]),
        .count(count_1), .limit(limit_1), .seg(seg_1), .an(an_1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock and settle just after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         pulses_m;
        int         pulses_s;
        logic       found;
        logic [3:0] prev_an;
        logic [3:0] an_exp  [8];
        logic [7:0] segm_exp[8];
        logic [7:0] segn_exp[8];

        an_exp   = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};
        segm_exp = '{8'hA4, 8'hA4, 8'h99, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        segn_exp = '{8'hA4, 8'hA4, 8'h99, 8'h99, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

        // Reset held for 10 cycles
        #1 rstn = 1'b0;
        repeat (10) tick();
        chk("rst_seg",   seg_m,   8'hFF);
        chk("rst_an",    an_m,    4'hF);
        chk("rst_count", count_m, 16'h0000);
        chk("rst_limit", limit_m, 1'b0);

        // Count up from zero through the 0009 -> 0010 carry
        rstn = 1'b1; go = 1'b1; up = 1'b1;
        repeat (4) tick();
        chk("cnt_1", count_m, 16'h0001);
        repeat (4) tick();
        chk("cnt_2", count_m, 16'h0002);
        repeat (28) tick();
        chk("cnt_9",     count_m, 16'h0009);
        chk("one_cnt_9", count_1, 4'h9);
        repeat (4) tick();
        chk("cnt_10",      count_m, 16'h0010);
        chk("one_wrap",    count_1, 4'h0);
        chk("one_limit",   limit_1, 1'b1);
        chk("one_an",      an_1,    1'b0);

        // Up-wrap at 9999 (wrap and saturate variants)
        load = 1'b1; load_val = 16'h9999;
        tick();
        load = 1'b0;
        chk("load_9999", count_m, 16'h9999);
        repeat (3) tick();
        chk("pre_wrap_cnt",   count_m, 16'h9999);
        chk("pre_wrap_limit", limit_m, 1'b0);
        tick();
        chk("wrap_cnt",       count_m, 16'h0000);
        chk("wrap_limit",     limit_m, 1'b1);
        chk("sat_hold_cnt",   count_s, 16'h9999);
        chk("sat_hold_limit", limit_s, 1'b1);
        tick();
        chk("wrap_limit_end", limit_m, 1'b0);

        // Three steps at the top: saturate pulses three times, wrap once
        load = 1'b1; load_val = 16'h9999;
        tick();
        load = 1'b0;
        pulses_m = 0;
        pulses_s = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (limit_m) pulses_m++;
            if (limit_s) pulses_s++;
        end
        chk("sat3_cnt",    count_s,  16'h9999);
        chk("sat3_pulses", pulses_s, 3);
        chk("wrap3_cnt",   count_m,  16'h0002);
        chk("wrap3_pulses", pulses_m, 1);

        // Down-wrap at 0000
        load = 1'b1; load_val = 16'h0000; up = 1'b0;
        tick();
        load = 1'b0;
        repeat (4) tick();
        chk("down_wrap_cnt",   count_m, 16'h9999);
        chk("down_wrap_limit", limit_m, 1'b1);
        chk("down_sat_cnt",    count_s, 16'h0000);
        chk("down_sat_limit",  limit_s, 1'b1);

        // Pause after two tick cycles; phase is kept on resume
        up = 1'b1; load = 1'b1; load_val = 16'h0000;
        tick();
        load = 1'b0;
        repeat (2) tick();
        go = 1'b0;
        repeat (20) tick();
        chk("pause_cnt", count_m, 16'h0000);
        go = 1'b1;
        tick();
        chk("resume_1", count_m, 16'h0000);
        tick();
        chk("resume_2", count_m, 16'h0001);

        // Load on a strobe cycle at 9999: load wins, no wrap, no limit; bad nibble -> 0
        load = 1'b1; load_val = 16'h9999;
        tick();
        load = 1'b0;
        repeat (3) tick();
        load = 1'b1; load_val = 16'h12A4;
        tick();
        load = 1'b0;
        chk("ldpri_cnt",   count_m, 16'h1204);
        chk("ldpri_limit", limit_m, 1'b0);
        chk("ldpri_slim",  limit_s, 1'b0);
        repeat (4) tick();
        chk("ldpri_next", count_m, 16'h1205);

        // Scan and blanking with 0042 held
        go = 1'b0; load = 1'b1; load_val = 16'h0042;
        tick();
        load = 1'b0;
        repeat (2) tick();
        found   = 1'b0;
        prev_an = an_m;
        for (int k = 0; k < 12 && !found; k++) begin
            tick();
            if (an_m == 4'hE && prev_an != 4'hE) found = 1'b1;
            else prev_an = an_m;
        end
        chk("scan_sync", found, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("scan_an_%0d", k),  an_m,  an_exp[k]);
            chk($sformatf("scan_seg_%0d", k), seg_m, segm_exp[k]);
            chk($sformatf("nb_seg_%0d", k),   seg_n, segn_exp[k]);
            tick();
        end

        // Asynchronous reset between edges
        #2 rstn = 1'b0;
        #1;
        chk("arst_count", count_m, 16'h0000);
        chk("arst_seg",   seg_m,   8'hFF);
        chk("arst_an",    an_m,    4'hF);
        chk("arst_limit", limit_m, 1'b0);
        chk("arst_scnt",  count_s, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
